wb_deserializer_rx: RTL and testbench
=====================================

// Module: wb_deserializer_rx
// PURPOSE
//   Receive side of the serial link: captures the 1-bit stream produced by the serializer stage,
//   frames it into 27-bit words (three 9-bit {k,8-bit} symbols) and buffers them in a small FIFO.
//   A Wishbone slave lets the CPU pop words and read/clear status. Single clock domain:
//   the serial line, the FIFO and the bus all run on clk_i.
// PARAMETERS
//   FRAME_BITS  27  payload bits per frame (3 x 9-bit symbols, symbol 2 in [26:18])
//   FIFO_DEPTH  4   words buffered; power of two, >= 2
//   ADR_DATA    0   word address of RX data register (read pops FIFO)
//   ADR_STATUS  1   word address of status/control register
// PORTS
//   clk_i   in   1   system clock, one serial bit per cycle
//   rst_i   in   1   synchronous reset, active-high
//   data_i  in   1   serial line in; idle level 0
//   CYC_I   in   1   Wishbone cycle
//   STB_I   in   1   Wishbone strobe
//   WE_I    in   1   Wishbone write enable
//   ADR_I   in   32  Wishbone address; only ADR_I[1:0] decoded
//   DAT_I   in   32  Wishbone write data
//   ACK_O   out  1   Wishbone acknowledge, registered single-cycle pulse
//   ERR_O   out  1   Wishbone error, registered, same cycle as ACK_O
//   DAT_O   out  32  Wishbone read data, registered, valid while ACK_O=1
//   irq_o   out  1   level: FIFO not empty OR overflow sticky set
// BEHAVIOUR
//   Reset (rst_i=1 at clk_i edge): FSM->IDLE, bit counter=0, shift reg=0, FIFO empty (level 0),
//     overflow=0, ACK_O=0, ERR_O=0, DAT_O=0, irq_o=0. Partial frame in progress is discarded.
//   Frame format: one start bit '1', then FRAME_BITS payload bits MSB first; line returns to 0.
//   FSM:
//     IDLE : data_i=1 -> SHIFT, cnt<=0. Else stay.
//     SHIFT: sr<={sr[FRAME_BITS-2:0],data_i}, cnt++; when cnt==FRAME_BITS-1 (last bit) -> PUSH.
//     PUSH : one cycle. FIFO not full -> write sr; full -> drop frame, overflow<=1. -> IDLE.
//     data_i is ignored in PUSH; next start bit is sampled no earlier than the following cycle.
//   Start-to-FIFO latency: last payload bit sampled at cycle N, word visible in level at N+2.
//   FIFO: circular, pointers wrap at FIFO_DEPTH, level 0..FIFO_DEPTH (extra pointer bit).
//     Push and pop in same cycle: both occur, level unchanged; allowed when full (pop frees slot
//     first, push accepted, no overflow) and when empty (pop ignored, push accepted).
//   Wishbone: request = CYC_I & STB_I & ~ACK_O. On request, next cycle ACK_O=1 for exactly one
//     cycle; ACK_O never asserts two cycles in a row, so held strobes complete every 2 cycles.
//     Read ADR_DATA: FIFO non-empty -> DAT_O={5'b0,word}, pop; empty -> DAT_O=0, ERR_O=1, no pop.
//     Read ADR_STATUS: DAT_O={21'b0, level[3:0], 4'b0, overflow, full, empty} at bits [10:7],[2:0].
//     Write ADR_STATUS: DAT_I[2]=1 clears overflow; other bits ignored; ERR_O=0.
//     Write ADR_DATA or any other address (ADR_I[1:0] = 2,3): ACK_O=1, ERR_O=1, no side effect.
//   Overflow set and CPU clear in same cycle: set wins (overflow stays 1).
//   Side effects (pop, clear) happen on the cycle ACK_O rises; DAT_O captured same edge.
//   irq_o is combinational from registered state (no extra latency beyond FIFO/overflow update).
// TESTING
//   1. Reset: drive rst_i 2 cycles -> ACK_O=0, ERR_O=0, DAT_O=0, irq_o=0, status reads 0x1.
//   2. Send '1' + 27'h1A5_5AA3 -> irq_o=1, status level=1; read ADR_DATA -> DAT_O=0x01A55AA3,
//      ERR_O=0; status then reads 0x1 and irq_o=0.
//   3. Send 5 back-to-back frames (words 1..5), no reads -> status full=1, overflow=1, level=4;
//      reads return 1,2,3,4 then 5th read ERR_O=1, DAT_O=0; write status DAT_I=0x4 clears overflow.
//   4. FIFO full, CPU pop ACK in same cycle as PUSH of new frame -> overflow stays 0, level=4,
//      read order preserved across pointer wrap.
//   5. Assert rst_i at payload bit 13 of a frame, then send a clean frame 27'h0000001 ->
//      only one word (0x00000001) in FIFO.
//   6. Write ADR_DATA and read ADR_I=3 -> ACK_O=1 with ERR_O=1, FIFO/overflow unchanged;
//      STB_I held 6 cycles -> exactly 3 ACK_O pulses.

Source files
------------

// File: rtl/wb_deserializer_rx.sv
// Serial frame receiver: frames a 1-bit line into 27-bit words, buffers them
// in a small FIFO and exposes data/status to the CPU through a Wishbone slave.
module wb_deserializer_rx #(
    parameter int unsigned FRAME_BITS = 27,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADR_DATA   = 0,
    parameter int unsigned ADR_STATUS = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_i,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O,
    output logic        irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FRAME_BITS);
    localparam logic [1:0]  A_DATA = 2'(ADR_DATA);
    localparam logic [1:0]  A_STAT = 2'(ADR_STATUS);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PUSH
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [FRAME_BITS-1:0] sr;

    logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           level;
    logic [3:0]            level4;
    logic                  empty;
    logic                  full;
    logic                  overflow;

    logic [1:0]            adr;
    logic                  req;
    logic                  pop;
    logic                  push_en;
    logic                  push_ok;
    logic                  ovf_set;
    logic                  ovf_clr;
    logic [31:0]           status_word;
    logic                  unused_bits;

    assign adr     = ADR_I[1:0];
    assign level   = wr_ptr - rd_ptr;
    assign level4  = 4'(level);
    assign empty   = (level == '0);
    assign full    = (level == LVL_FULL);
    assign irq_o   = ~empty | overflow;

    assign req     = CYC_I & STB_I & ~ACK_O;
    assign pop     = req & ~WE_I & (adr == A_DATA) & ~empty;
    assign push_en = (state == ST_PUSH);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push_en & (~full | pop);
    assign ovf_set = push_en & full & ~pop;
    assign ovf_clr = req & WE_I & (adr == A_STAT) & DAT_I[2];

    assign status_word = {21'b0, level4, 4'b0, overflow, full, empty};
    assign unused_bits = ^{ADR_I[31:2], DAT_I[31:3], DAT_I[1:0]};

    // Frame capture: start bit, then FRAME_BITS payload bits MSB first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_i) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    sr  <= {sr[FRAME_BITS-2:0], data_i};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= sr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Bus response: ACK_O gates the next request, so held strobes complete every other cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            DAT_O <= '0;
        end else if (req) begin
            ACK_O <= 1'b1;
            ERR_O <= 1'b0;
            DAT_O <= '0;
            if (WE_I) begin
                if (adr != A_STAT) begin
                    ERR_O <= 1'b1;
                end
            end else if (adr == A_DATA) begin
                if (empty) begin
                    ERR_O <= 1'b1;
                end else begin
                    DAT_O <= 32'(mem[rd_ptr[AW-1:0]]);
                end
            end else if (adr == A_STAT) begin
                DAT_O <= status_word;
            end else begin
                ERR_O <= 1'b1;
            end
        end else begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_deserializer_rx.sv
// Directed bench for wb_deserializer_rx: bus expectations go into a queue and
// a negedge monitor pops and compares them whenever ACK_O is seen.
module tb_wb_deserializer_rx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_i;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic        ACK_O;
    logic        ERR_O;
    logic [31:0] DAT_O;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        bit          chk_dat;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    wb_deserializer_rx #(
        .FRAME_BITS(27),
        .FIFO_DEPTH(4),
        .ADR_DATA  (0),
        .ADR_STATUS(1)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .data_i(data_i),
        .CYC_I (CYC_I),
        .STB_I (STB_I),
        .WE_I  (WE_I),
        .ADR_I (ADR_I),
        .DAT_I (DAT_I),
        .ACK_O (ACK_O),
        .ERR_O (ERR_O),
        .DAT_O (DAT_O),
        .irq_o (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (ACK_O === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
                mon_e = q.pop_front();
                check({mon_e.name, "_err"}, 32'(ERR_O), 32'(mon_e.err));
                if (mon_e.chk_dat) check({mon_e.name, "_dat"}, DAT_O, mon_e.dat);
            end
        end
    end

    task automatic wb(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                      input logic [31:0] exp_dat, input logic exp_err, input bit chk_dat,
                      input string name);
        int n;
        @(negedge clk_i);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = {30'b0, adr}; DAT_I = wdat;
        q.push_back('{exp_dat, exp_err, chk_dat, name});
        n = 0;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (ACK_O !== 1'b1 && n < 4);
        if (ACK_O !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_ack_timeout actual=0 required=1", name);
            void'(q.pop_back());
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp_dat, input logic exp_err,
                      input string name);
        wb(1'b0, adr, 32'h0, exp_dat, exp_err, 1'b1, name);
    endtask

    // Start bit plus 27 payload bits; the final negedge falls in the PUSH cycle,
    // where an optional pop can be launched to land on the same edge as the push.
    task automatic send_frame(input logic [26:0] w, input bit pop_at_push, input logic [31:0] pop_exp);
        @(negedge clk_i); data_i = 1'b1;
        for (int i = 26; i >= 0; i--) begin
            @(negedge clk_i); data_i = w[i];
        end
        @(negedge clk_i); data_i = 1'b0;
        if (pop_at_push) begin
            CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h0;
            q.push_back('{pop_exp, 1'b0, 1'b1, "pop_at_push"});
            @(posedge clk_i); #1;
            CYC_I = 1'b0; STB_I = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        rst_i = 1'b1; data_i = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        ADR_I = '0; DAT_I = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // 1: reset state
        check("rst_ack", 32'(ACK_O), 32'h0);
        check("rst_err", 32'(ERR_O), 32'h0);
        check("rst_dat", DAT_O, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        rd(2'd1, 32'h1, 1'b0, "rst_status");

        // 2: single frame
        send_frame(27'h1A5_5AA3, 1'b0, 32'h0);
        repeat (2) @(negedge clk_i);
        check("t2_irq_set", 32'(irq_o), 32'h1);
        rd(2'd1, 32'h80, 1'b0, "t2_status_lvl1");
        rd(2'd0, 32'h01A5_5AA3, 1'b0, "t2_data");
        rd(2'd1, 32'h1, 1'b0, "t2_status_empty");
        @(negedge clk_i);
        check("t2_irq_clr", 32'(irq_o), 32'h0);

        // 3: overflow with five back-to-back frames
        for (int i = 1; i <= 5; i++) send_frame(27'(i), 1'b0, 32'h0);
        repeat (2) @(negedge clk_i);
        check("t3_irq", 32'(irq_o), 32'h1);
        rd(2'd1, 32'h206, 1'b0, "t3_status_full_ovf");
        rd(2'd0, 32'h1, 1'b0, "t3_data1");
        rd(2'd0, 32'h2, 1'b0, "t3_data2");
        rd(2'd0, 32'h3, 1'b0, "t3_data3");
        rd(2'd0, 32'h4, 1'b0, "t3_data4");
        rd(2'd0, 32'h0, 1'b1, "t3_empty_read");
        rd(2'd1, 32'h5, 1'b0, "t3_status_ovf_empty");
        wb(1'b1, 2'd1, 32'h4, 32'h0, 1'b0, 1'b0, "t3_clear");
        rd(2'd1, 32'h1, 1'b0, "t3_status_cleared");
        @(negedge clk_i);
        check("t3_irq_clr", 32'(irq_o), 32'h0);

        // 4: pop coincides with push into a full FIFO, across pointer wrap
        for (int i = 16; i < 20; i++) send_frame(27'(i), 1'b0, 32'h0);
        send_frame(27'h14, 1'b1, 32'h10);
        repeat (2) @(negedge clk_i);
        rd(2'd1, 32'h202, 1'b0, "t4_status_full_no_ovf");
        rd(2'd0, 32'h11, 1'b0, "t4_data11");
        rd(2'd0, 32'h12, 1'b0, "t4_data12");
        rd(2'd0, 32'h13, 1'b0, "t4_data13");
        rd(2'd0, 32'h14, 1'b0, "t4_data14");
        rd(2'd1, 32'h1, 1'b0, "t4_status_empty");

        // 5: reset mid-frame discards the partial frame
        @(negedge clk_i); data_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i); data_i = (i % 2 == 0);
        end
        @(negedge clk_i); data_i = 1'b0; rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("t5_irq_after_rst", 32'(irq_o), 32'h0);
        send_frame(27'h000_0001, 1'b0, 32'h0);
        repeat (40) @(negedge clk_i);
        rd(2'd1, 32'h80, 1'b0, "t5_status_lvl1");
        rd(2'd0, 32'h1, 1'b0, "t5_data");
        rd(2'd1, 32'h1, 1'b0, "t5_status_empty");

        // 6: illegal accesses and held strobe
        send_frame(27'h7FF_FFFF, 1'b0, 32'h0);
        repeat (2) @(negedge clk_i);
        wb(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, "t6_write_data");
        wb(1'b0, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0, "t6_read_adr3");
        wb(1'b1, 2'd2, 32'h4, 32'h0, 1'b1, 1'b0, "t6_write_adr2");
        rd(2'd1, 32'h80, 1'b0, "t6_status_unchanged");
        rd(2'd0, 32'h07FF_FFFF, 1'b0, "t6_data_ones");
        repeat (2) @(negedge clk_i);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h1;
        for (int i = 0; i < 3; i++) q.push_back('{32'h1, 1'b0, 1'b1, "t6_held_status"});
        acks = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (ACK_O === 1'b1) acks++;
        end
        CYC_I = 1'b0; STB_I = 1'b0;
        check("t6_held_ack_count", 32'(acks), 32'd3);

        repeat (5) @(negedge clk_i);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
